// File: rtl/alu_muldiv_pkg.sv
// Shared opcode and FSM state encodings for alu_muldiv.
// Optional divider: ALU_MULDIV_DIV_EN adds the DIV state.
package types;

   typedef enum logic [3:0] {
      ALU_AND  = 4'd0,
      ALU_OR   = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_SLT  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9,
      ALU_MUL  = 4'd10,
      ALU_DIVU = 4'd11,
      ALU_REMU = 4'd12
   } alu_oper_type;

`ifdef ALU_MULDIV_DIV_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2
   } alu_muldiv_state_type;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1
   } alu_muldiv_state_type;
`endif

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative datapath: shift-add multiply and (with ALU_MULDIV_DIV_EN) restoring
// unsigned divide, one bit per step, WIDTH steps per operation.
module alu_muldiv_iter
   import types::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             step_i,
`ifdef ALU_MULDIV_DIV_EN
   input  logic             div_i,
   input  logic             rem_i,
`endif
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             last_o,
   output logic [WIDTH-1:0] result_o
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] acc_q, x_q, y_q;
   logic [WIDTH-1:0] mul_acc_d;

   // Multiply: x is the shifting multiplicand, y the shifting multiplier.
   assign mul_acc_d = acc_q + (y_q[0] ? x_q : '0);
   assign last_o    = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef ALU_MULDIV_DIV_EN
   logic             is_div_q, is_rem_q;
   logic [WIDTH:0]   trial, diff;
   logic             ge;
   logic [WIDTH-1:0] rem_d, quo_d;

   // Divide: acc holds the partial remainder, y shifts the dividend out and quotient in.
   assign trial    = {acc_q, y_q[WIDTH-1]};
   assign diff     = trial - {1'b0, x_q};
   assign ge       = ~diff[WIDTH];
   assign rem_d    = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
   assign quo_d    = {y_q[WIDTH-2:0], ge};
   assign result_o = is_div_q ? (is_rem_q ? rem_d : quo_d) : mul_acc_d;
`else
   assign result_o = mul_acc_d;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
         acc_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
`ifdef ALU_MULDIV_DIV_EN
         is_div_q <= 1'b0;
         is_rem_q <= 1'b0;
`endif
      end else if (start_i) begin
         cnt_q <= '0;
         acc_q <= '0;
`ifdef ALU_MULDIV_DIV_EN
         is_div_q <= div_i;
         is_rem_q <= rem_i;
         x_q      <= div_i ? b_i : a_i;
         y_q      <= div_i ? a_i : b_i;
`else
         x_q <= a_i;
         y_q <= b_i;
`endif
      end else if (step_i) begin
         cnt_q <= cnt_q + 1'b1;
`ifdef ALU_MULDIV_DIV_EN
         if (is_div_q) begin
            acc_q <= rem_d;
            y_q   <= quo_d;
         end else begin
            acc_q <= mul_acc_d;
            x_q   <= x_q << 1;
            y_q   <= y_q >> 1;
         end
`else
         acc_q <= mul_acc_d;
         x_q   <= x_q << 1;
         y_q   <= y_q >> 1;
`endif
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with iterative multiply and optional divide behind a valid/ready handshake.
// Define ALU_MULDIV_DIV_EN to enable DIVU/REMU; otherwise they behave as AND.
module alu_muldiv
   import types::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_oper_type     sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             zero
);

   localparam int SH_W = $clog2(WIDTH);

   alu_muldiv_state_type state_q;
   logic             out_valid_q, zero_q;
   logic [WIDTH-1:0] s_q, alu_res, iter_res;
   logic             accept, iter_start, iter_last, div_go;
   logic [SH_W-1:0]  shamt;

   assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign shamt    = b[SH_W-1:0];

`ifdef ALU_MULDIV_DIV_EN
   assign div_go = ((sel == ALU_DIVU) || (sel == ALU_REMU)) && (b != '0);
`else
   assign div_go = 1'b0;
`endif
   assign iter_start = accept && ((sel == ALU_MUL) || div_go);

   always_comb begin
      alu_res = a & b;
      case (sel)
         ALU_OR:   alu_res = a | b;
         ALU_NOR:  alu_res = ~(a | b);
         ALU_ADD:  alu_res = a + b;
         ALU_SUB:  alu_res = a - b;
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         ALU_SLL:  alu_res = a << shamt;
         ALU_SRL:  alu_res = a >> shamt;
         ALU_SRA:  alu_res = $signed(a) >>> shamt;
`ifdef ALU_MULDIV_DIV_EN
         // Only reached for a zero divisor; nonzero divisors go iterative.
         ALU_DIVU: alu_res = '1;
         ALU_REMU: alu_res = a;
`endif
         default:  alu_res = a & b;
      endcase
   end

   alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk_i    (clk),
      .reset_i  (reset),
      .start_i  (iter_start),
      .step_i   (state_q != IDLE),
`ifdef ALU_MULDIV_DIV_EN
      .div_i    (sel != ALU_MUL),
      .rem_i    (sel == ALU_REMU),
`endif
      .a_i      (a),
      .b_i      (b),
      .last_o   (iter_last),
      .result_o (iter_res)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         s_q         <= '0;
         zero_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (sel == ALU_MUL) begin
                     state_q     <= MUL;
                     out_valid_q <= 1'b0;
                  end
`ifdef ALU_MULDIV_DIV_EN
                  else if (div_go) begin
                     state_q     <= DIV;
                     out_valid_q <= 1'b0;
                  end
`endif
                  else begin
                     s_q         <= alu_res;
                     zero_q      <= (alu_res == '0);
                     out_valid_q <= 1'b1;
                  end
               end else if (out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               if (iter_last) begin
                  state_q     <= IDLE;
                  s_q         <= iter_res;
                  zero_q      <= (iter_res == '0);
                  out_valid_q <= 1'b1;
               end
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign s         = s_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): directed literal cases plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_alu_muldiv;
   import types::*;

   localparam int WIDTH = 32;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   alu_oper_type sel = ALU_AND;
   logic        in_ready, out_valid, zero;
   logic [31:0] s;

   int checks = 0;
   int failures = 0;

   int          m_busy = 0;
   bit          m_ov = 1'b0;
   logic [31:0] m_s = '0;
   logic [31:0] m_pend = '0;
   bit          chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_muldiv #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .zero      (zero)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_op(input int op, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      case (op)
         1:  return x | y;
         2:  return x + y;
         3:  return x - y;
         4:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         5:  return ~(x | y);
         6:  return (x < y) ? 32'd1 : 32'd0;
         7:  return x << y[4:0];
         8:  return x >> y[4:0];
         9:  return $signed(x) >>> y[4:0];
         10: begin
            p = 64'(x) * 64'(y);
            return p[31:0];
         end
`ifdef ALU_MULDIV_DIV_EN
         11: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         12: return (y == 0) ? x : x % y;
`endif
         default: return x & y;
      endcase
   endfunction

   function automatic int latency(input int op, input logic [31:0] y);
      if (op == 10) return WIDTH + 1;
`ifdef ALU_MULDIV_DIV_EN
      if ((op == 11 || op == 12) && y != 0) return WIDTH + 1;
`endif
      return 1;
   endfunction

   // Reference model: advances on each rising edge using pre-edge inputs.
   initial forever begin
      bit rdy;
      int lat;
      logic [31:0] r;
      @(posedge clk);
      rdy = (m_busy == 0) && (!m_ov || out_ready);
      if (reset) begin
         m_busy = 0;
         m_ov = 1'b0;
         m_s = '0;
      end else if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin
            m_ov = 1'b1;
            m_s = m_pend;
         end
      end else if (in_valid && rdy) begin
         r = ref_op(int'(sel), a, b);
         lat = latency(int'(sel), b);
         if (lat > 1) begin
            m_busy = lat - 1;
            m_pend = r;
            m_ov = 1'b0;
         end else begin
            m_ov = 1'b1;
            m_s = r;
         end
      end else if (m_ov && out_ready) begin
         m_ov = 1'b0;
      end
   end

   // Compare process on the falling edge.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("model_in_ready", in_ready, (m_busy == 0) && (!m_ov || out_ready));
         chk("model_out_valid", out_valid, m_ov);
         if (m_ov) begin
            chk("model_s", s, m_s);
            chk("model_zero", zero, m_s == 0);
         end
      end
   end

   task automatic run_op(input alu_oper_type op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_s, input int exp_lat, input string nm);
      int n;
      bit rdy_seen;
      @(posedge clk); #1;
      in_valid = 1'b1; sel = op; a = av; b = bv; out_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_accept"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; sel = ALU_ADD; a = $urandom; b = $urandom;
      n = 1;
      rdy_seen = 1'b0;
      while (!out_valid && n < 200) begin
         if (in_ready) rdy_seen = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      chk({nm, "_latency"}, n, exp_lat);
      chk({nm, "_s"}, s, exp_s);
      chk({nm, "_zero"}, zero, exp_s == 0);
      if (exp_lat > 1) chk({nm, "_busy_ready"}, rdy_seen, 0);
   endtask

   initial begin
      bit seen;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_s", s, 0);
      chk("reset_zero", zero, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);

      run_op(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, "add_wrap");
      run_op(ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, "sub");
      run_op(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, "slt");
      run_op(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, "sltu");
      run_op(ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, "sra");
      run_op(ALU_SRL, 32'h8000_0000, 32'd36, 32'h0800_0000, 1, "srl");
      run_op(ALU_NOR, 32'h0F0F_0000, 32'h0000_F0F0, 32'hF0F0_0F0F, 1, "nor");
      run_op(ALU_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 33, "mul");
      run_op(ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul_neg");
      run_op(alu_oper_type'(4'd14), 32'd12, 32'd5, 32'd4, 1, "undef_sel");
`ifdef ALU_MULDIV_DIV_EN
      run_op(ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu");
      run_op(ALU_REMU, 32'd100, 32'd7, 32'd2, 33, "remu");
      run_op(ALU_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0");
      run_op(ALU_REMU, 32'd9, 32'd0, 32'd9, 1, "remu_by0");
`else
      run_op(ALU_DIVU, 32'd12, 32'd5, 32'd4, 1, "divu_as_and");
`endif

      // Backpressure: hold the result, offer another op that must not be taken.
      @(posedge clk); #1;
      in_valid = 1'b1; sel = ALU_ADD; a = 32'd40; b = 32'd2; out_ready = 1'b0;
      @(posedge clk); #1;
      sel = ALU_SUB; a = 32'd1; b = 32'd1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_s", s, 42);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sel = ALU_ADD; a = 32'(k * 3); b = 32'd100;
         @(negedge clk);
         chk("stream_in_ready", in_ready, 1);
         @(posedge clk); #1;
         chk("stream_out_valid", out_valid, 1);
         chk("stream_s", s, 32'(k * 3 + 100));
      end
      in_valid = 1'b0;

      // Reset in the middle of a multiply.
      @(posedge clk); #1;
      in_valid = 1'b1; sel = ALU_MUL; a = 32'd7; b = 32'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_s", s, 0);
      chk("rst_zero", zero, 0);
      chk("rst_in_ready", in_ready, 1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("rst_no_result", seen, 0);
      run_op(ALU_ADD, 32'd2, 32'd3, 32'd5, 1, "add_after_rst");

      // Randomized traffic, checked by the compare process.
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         reset = ($urandom_range(0, 599) == 0);
         in_valid = ($urandom_range(0, 1) == 1);
         sel = alu_oper_type'(4'($urandom_range(0, 15)));
         a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
